// File: rtl/fsbm_pkg.sv
// Shared definitions for the full-search block-matching datapath.
// - state_e   : min-select FSM states
// - SAD_W_DEF : default SAD width (matches PE sum)
// - SAD_MAX   : all-ones SAD at the default width, the "nothing seen yet" value
package fsbm_pkg;

  localparam int SAD_W_DEF = 12;

  localparam logic [SAD_W_DEF-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sad_raster_cnt.sv
// Raster-order x/y position counter over an NX x NY candidate grid.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : force position to (0,0); wins over inc
//   inc        : advance one candidate (x fastest, both wrap at the end)
//   x, y       : current candidate column / row
//   last       : current position is (NX-1, NY-1)
module sad_raster_cnt #(
  parameter int NX = 16,
  parameter int NY = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [$clog2(NX)-1:0] x,
  output logic [$clog2(NY)-1:0] y,
  output logic                  last
);

  localparam int XW = $clog2(NX);
  localparam int YW = $clog2(NY);
  localparam logic [XW-1:0] X_LAST = XW'(NX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(NY - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (inc) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/sad_min_select.sv
// Minimum-SAD selector: consumes one candidate SAD per sad_valid beat in
// raster order and reports the best (lowest) SAD and its (x,y) at end of
// the search window with a one-cycle done pulse.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   start             : begin a window (honoured in IDLE / DONE only)
//   sad_valid, sad    : candidate SAD beat from the PE array
//   busy              : window scan in progress
//   done              : one-cycle pulse, best_* final
//   best_sad/x/y      : running / final minimum and its position
module sad_min_select
  import fsbm_pkg::*;
#(
  parameter int SAD_W = SAD_W_DEF,
  parameter int NX    = 16,
  parameter int NY    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sad_valid,
  input  logic [SAD_W-1:0]      sad,
  output logic                  busy,
  output logic                  done,
  output logic [SAD_W-1:0]      best_sad,
  output logic [$clog2(NX)-1:0] best_x,
  output logic [$clog2(NY)-1:0] best_y
);

  localparam int XW = $clog2(NX);
  localparam int YW = $clog2(NY);

  state_e          state_q, state_d;
  logic            first_q, first_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [XW-1:0]   best_x_q, best_x_d;
  logic [YW-1:0]   best_y_q, best_y_d;

  logic          cnt_clr, cnt_inc, cnt_last;
  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;

  sad_raster_cnt #(.NX(NX), .NY(NY)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .x    (cnt_x),
    .y    (cnt_y),
    .last (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    best_sad_d = best_sad_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        // Beats are never taken here, even alongside start.
        if (start) begin
          state_d = SCAN;
          cnt_clr = 1'b1;
          first_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (sad_valid) begin
          cnt_inc = 1'b1;
          first_d = 1'b0;
          // First beat loads unconditionally so an all-ones window still
          // reports (0,0); strict < keeps the earliest of equal minima.
          if (first_q || (sad < best_sad_q)) begin
            best_sad_d = sad;
            best_x_d   = cnt_x;
            best_y_d   = cnt_y;
          end
          if (cnt_last) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      first_q    <= 1'b0;
      best_sad_q <= '1;
      best_x_q   <= '0;
      best_y_q   <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      best_sad_q <= best_sad_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
    end
  end

  assign busy     = (state_q == SCAN);
  assign done     = (state_q == DONE);
  assign best_sad = best_sad_q;
  assign best_x   = best_x_q;
  assign best_y   = best_y_q;

endmodule

// File: tb/tb_sad_min_select.sv
// Bench for sad_min_select (NX=NY=4): directed windows; expected results
// go into a scoreboard queue, a negedge monitor checks them on done.
module tb_sad_min_select;

  localparam int SAD_W = 12;
  localparam int NX    = 4;
  localparam int NY    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sad_valid = 1'b0;
  logic [SAD_W-1:0] sad = '0;
  logic             busy, done;
  logic [SAD_W-1:0] best_sad;
  logic [1:0]       best_x, best_y;

  sad_min_select #(.SAD_W(SAD_W), .NX(NX), .NY(NY)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sad_valid(sad_valid),
    .sad      (sad),
    .busy     (busy),
    .done     (done),
    .best_sad (best_sad),
    .best_x   (best_x),
    .best_y   (best_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SAD_W-1:0] sad;
    logic [1:0]       x;
    logic [1:0]       y;
    int               cyc;
    string            tag;
  } exp_t;

  exp_t exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  logic [SAD_W-1:0] data [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.tag, "_done_cycle"}, cyc, e.cyc);
        chk({e.tag, "_best_sad"}, 32'(best_sad), 32'(e.sad));
        chk({e.tag, "_best_x"}, 32'(best_x), 32'(e.x));
        chk({e.tag, "_best_y"}, 32'(best_y), 32'(e.y));
        chk({e.tag, "_busy_in_done"}, 32'(busy), 32'd0);
      end
    end
  end

  task automatic fill(input logic [SAD_W-1:0] v);
    for (int i = 0; i < 16; i++) data[i] = v;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_best_sad"}, 32'(best_sad), 32'hFFF);
    chk({nm, "_best_x"}, 32'(best_x), 32'd0);
    chk({nm, "_best_y"}, 32'(best_y), 32'd0);
  endtask

  // Start cycle; optionally with a simultaneous beat that must be dropped.
  task automatic do_start(input logic with_beat, input string nm);
    start = 1'b1;
    sad_valid = with_beat;
    sad = with_beat ? 12'h001 : 12'h000;
    @(posedge clk); #1;
    start = 1'b0; sad_valid = 1'b0; sad = '0;
    chk({nm, "_busy_after_start"}, 32'(busy), 32'd1);
  endtask

  // 16 beats from data[]; with gaps, 1-3 idle cycles (sad=0) between beats
  // and a stray start in one gap. Expectation is pushed after the last beat.
  task automatic send_window(input bit gaps, input logic [SAD_W-1:0] es,
                             input logic [1:0] ex, input logic [1:0] ey,
                             input string nm);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      sad_valid = 1'b1; sad = data[i];
      @(posedge clk); #1;
      sad_valid = 1'b0; sad = '0;
      if (gaps && i < 15) begin
        for (int g = 0; g < (i % 3) + 1; g++) begin
          if (i == 5 && g == 0) start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    end
    e.sad = es; e.x = ex; e.y = ey; e.cyc = cyc; e.tag = nm;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the monitor to consume all expectations, then check
  // that the window returned to IDLE with results held.
  task automatic finish_window(input logic [SAD_W-1:0] es, input logic [1:0] ex,
                               input logic [1:0] ey, input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 5) begin
      @(negedge clk); t++;
    end
    if (exp_q.size() != 0) begin
      chk({nm, "_done_seen"}, 32'd0, 32'd1);
      exp_q.delete();
    end
    @(posedge clk); #1;
    chk({nm, "_done_pulse_end"}, 32'(done), 32'd0);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    chk({nm, "_hold_sad"}, 32'(best_sad), 32'(es));
    chk({nm, "_hold_xy"}, {30'd0, best_x} | ({30'd0, best_y} << 2), {30'd0, ex} | ({30'd0, ey} << 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle hold
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (5) @(posedge clk); #1;
      check_reset_vals("idle_hold");
    end

    // Single minimum at index 9 -> (1,2)
    fill(12'h100); data[9] = 12'h020;
    do_start(1'b0, "min9");
    send_window(1'b0, 12'h020, 2'd1, 2'd2, "min9");
    finish_window(12'h020, 2'd1, 2'd2, "min9");

    // Tie at indices 3 and 12 -> earliest (3,0); start carries a beat to drop
    fill(12'h200); data[3] = 12'h010; data[12] = 12'h010;
    do_start(1'b1, "tie");
    send_window(1'b0, 12'h010, 2'd3, 2'd0, "tie");
    finish_window(12'h010, 2'd3, 2'd0, "tie");

    // Same as min9 with gaps (sad=0 while invalid) and a stray start
    fill(12'h100); data[9] = 12'h020;
    do_start(1'b0, "gaps");
    send_window(1'b1, 12'h020, 2'd1, 2'd2, "gaps");
    finish_window(12'h020, 2'd1, 2'd2, "gaps");

    // All ones -> first-beat load at (0,0); then restart from DONE
    fill(12'hFFF);
    do_start(1'b0, "allff");
    send_window(1'b0, 12'hFFF, 2'd0, 2'd0, "allff");
    chk("allff_done_now", 32'(done), 32'd1);
    // Decreasing values: minimum is the final beat (3,3)
    for (int i = 0; i < 16; i++) data[i] = 12'(12'h200 - i * 12'h010);
    do_start(1'b0, "b2b");
    send_window(1'b0, 12'h110, 2'd3, 2'd3, "b2b");
    finish_window(12'h110, 2'd3, 2'd3, "b2b");

    // Reset after 7 beats of a window
    fill(12'h100);
    do_start(1'b0, "rst");
    for (int i = 0; i < 7; i++) begin
      sad_valid = 1'b1; sad = data[i];
      @(posedge clk); #1;
    end
    sad_valid = 1'b0; sad = '0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_async");
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sad_valid = 1'b1; sad = 12'h001;
      @(posedge clk); #1;
    end
    sad_valid = 1'b0; sad = '0;
    check_reset_vals("rst_nostart");
    // Valid zero SAD at index 10 -> (2,2)
    fill(12'h080); data[6] = 12'h005; data[10] = 12'h000;
    do_start(1'b0, "post_rst");
    send_window(1'b0, 12'h000, 2'd2, 2'd2, "post_rst");
    finish_window(12'h000, 2'd2, 2'd2, "post_rst");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
